// File: rtl/router_pkg.sv
// Shared router definitions: flit geometry, VC count and flit type encodings.
package router_pkg;

  localparam int FLIT_W = 35;
  localparam int NUM_VC = 2;

  // Flit type lives in the two MSBs of every flit.
  localparam logic [1:0] FT_SINGLE = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_BODY   = 2'b10;
  localparam logic [1:0] FT_TAIL   = 2'b11;

  function automatic logic [NUM_VC-1:0] vc_onehot(input logic vc);
    logic [NUM_VC-1:0] oh;
    oh = '0;
    oh[vc] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel flit FIFO with a registered full flag and overflow-drop indication.
module vc_fifo #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int FLIT_W = 35
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FLIT_W-1:0] din,
  input  logic              pop,
  output logic [FLIT_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              drop
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              full_q;
  logic              push_ok, pop_ok;

  // A full FIFO still accepts a push when the same edge frees a slot.
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && (!full_q || pop_ok);
    drop     = push && full_q && !pop_ok;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = full_q;

endmodule

// File: rtl/vc_input_buffer.sv
// Link-side router input stage: per-VC FIFOs, round-robin VC arbiter with wormhole lock,
// registered output flit and per-flit credit return.
module vc_input_buffer
  import router_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              RST_,
  input  logic [FLIT_W-1:0] LDATA,
  input  logic              LVALID,
  input  logic              LVCH,
  output logic [NUM_VC-1:0] LCRED,
  output logic [FLIT_W-1:0] IDATA,
  output logic              IVALID,
  output logic              IVCH,
  input  logic [NUM_VC-1:0] OACK,
  input  logic [NUM_VC-1:0] ORDY,
  input  logic [NUM_VC-1:0] OLCK,
  output logic [NUM_VC-1:0] FULL,
  output logic              OVF_ERR
);

  logic [FLIT_W-1:0] fifo_dout [NUM_VC];
  logic [NUM_VC-1:0] fifo_empty, fifo_full, fifo_drop;
  logic [NUM_VC-1:0] push_vec, pop_vec, elig;
  logic              load, grant_ok, grant_vc;

  logic [FLIT_W-1:0] idata_q;
  logic              ivalid_q, ivch_q, last_vc_q, ovf_q;
  logic [NUM_VC-1:0] lcred_q;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign push_vec[v] = LVALID && (LVCH == 1'(v));

    vc_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .FLIT_W(FLIT_W)) u_fifo (
      .clk   (clk),
      .rst   (RST_),
      .push  (push_vec[v]),
      .din   (LDATA),
      .pop   (pop_vec[v]),
      .dout  (fifo_dout[v]),
      .full  (fifo_full[v]),
      .empty (fifo_empty[v]),
      .drop  (fifo_drop[v])
    );
  end

  // A locked last_vc masks the other VC so packets never interleave on the router port.
  always_comb begin
    elig = ORDY & ~fifo_empty;
    if (OLCK[last_vc_q]) elig = elig & vc_onehot(last_vc_q);
    load     = !ivalid_q || OACK[ivch_q];
    grant_vc = last_vc_q;
    grant_ok = 1'b0;
    if (elig[~last_vc_q]) begin
      grant_vc = ~last_vc_q;
      grant_ok = 1'b1;
    end else if (elig[last_vc_q]) begin
      grant_ok = 1'b1;
    end
    pop_vec = (load && grant_ok) ? vc_onehot(grant_vc) : '0;
  end

  always_ff @(posedge clk or posedge RST_) begin
    if (RST_) begin
      idata_q   <= '0;
      ivalid_q  <= 1'b0;
      ivch_q    <= 1'b0;
      last_vc_q <= 1'b1;
      lcred_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      lcred_q <= pop_vec;
      ovf_q   <= ovf_q | (|fifo_drop);
      if (load) begin
        ivalid_q <= grant_ok;
        if (grant_ok) begin
          idata_q   <= fifo_dout[grant_vc];
          ivch_q    <= grant_vc;
          last_vc_q <= grant_vc;
        end
      end
    end
  end

  assign IDATA   = idata_q;
  assign IVALID  = ivalid_q;
  assign IVCH    = ivch_q;
  assign LCRED   = lcred_q;
  assign FULL    = fifo_full;
  assign OVF_ERR = ovf_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed scoreboard bench for vc_input_buffer: stimulus queues expected flits, a monitor checks transfers.
module tb_vc_input_buffer;
  import router_pkg::*;

  typedef struct packed {
    logic              vc;
    logic [FLIT_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              RST_;
  logic [FLIT_W-1:0] LDATA;
  logic              LVALID, LVCH;
  logic [1:0]        LCRED;
  logic [FLIT_W-1:0] IDATA;
  logic              IVALID, IVCH;
  logic [1:0]        OACK, ORDY, OLCK;
  logic [1:0]        FULL;
  logic              OVF_ERR;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   credCnt0   = 0;
  int   credCnt1   = 0;
  int   delivered  = 0;

  always #5 clk = ~clk;

  vc_input_buffer dut (
    .clk     (clk),
    .RST_    (RST_),
    .LDATA   (LDATA),
    .LVALID  (LVALID),
    .LVCH    (LVCH),
    .LCRED   (LCRED),
    .IDATA   (IDATA),
    .IVALID  (IVALID),
    .IVCH    (IVCH),
    .OACK    (OACK),
    .ORDY    (ORDY),
    .OLCK    (OLCK),
    .FULL    (FULL),
    .OVF_ERR (OVF_ERR)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic vc, input logic [FLIT_W-1:0] data);
    LVALID = 1'b1;
    LVCH   = vc;
    LDATA  = data;
    tick();
    LVALID = 1'b0;
  endtask

  task automatic resetDut();
    RST_   = 1'b1;
    LVALID = 1'b0;
    tick();
    tick();
    RST_ = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (expQ.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    checkOutput({name, " drain left"}, 64'(expQ.size()), 64'd0);
    repeat (3) tick();
  endtask

  function automatic logic [FLIT_W-1:0] mkFlit(input logic [1:0] t, input logic vc, input int idx);
    return {t, 28'hC0FFEE0, vc, 4'(idx)};
  endfunction

  // Monitor: every accepted transfer must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!RST_) begin
        if (LCRED[0]) credCnt0++;
        if (LCRED[1]) credCnt1++;
        if (IVALID && OACK[IVCH]) begin
          if (expQ.size() == 0) begin
            checkOutput("spurious xfer", 64'(IVALID), 64'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("xfer vc", 64'(IVCH), 64'(e.vc));
            checkOutput("xfer data", 64'(IDATA), 64'(e.data));
            delivered++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c0, c1, d0, seen;
    logic [FLIT_W-1:0] fA, fB, f;

    RST_ = 1'b1; LVALID = 1'b0; LVCH = 1'b0; LDATA = '0;
    OACK = 2'b00; ORDY = 2'b00; OLCK = 2'b00;
    tick();
    checkOutput("rst IVALID", 64'(IVALID), 64'd0);
    checkOutput("rst IDATA", 64'(IDATA), 64'd0);
    checkOutput("rst IVCH", 64'(IVCH), 64'd0);
    checkOutput("rst LCRED", 64'(LCRED), 64'd0);
    checkOutput("rst FULL", 64'(FULL), 64'd0);
    checkOutput("rst OVF", 64'(OVF_ERR), 64'd0);
    tick();
    RST_ = 1'b0;

    // Test 1: single flit latency and credit pulse.
    $display("[TB] test 1: single flit latency");
    OACK = 2'b11; ORDY = 2'b11;
    c0 = credCnt0;
    f  = mkFlit(FT_SINGLE, 1'b0, 1);
    expQ.push_back('{1'b0, f});
    applyStimulus(1'b0, f);
    checkOutput("t1 IVALID early", 64'(IVALID), 64'd0);
    tick();
    checkOutput("t1 IVALID", 64'(IVALID), 64'd1);
    checkOutput("t1 IVCH", 64'(IVCH), 64'd0);
    checkOutput("t1 IDATA", 64'(IDATA), 64'(f));
    checkOutput("t1 LCRED", 64'(LCRED), 64'b01);
    tick();
    checkOutput("t1 IVALID after xfer", 64'(IVALID), 64'd0);
    checkOutput("t1 LCRED after", 64'(LCRED), 64'b00);
    waitDrain("t1");
    checkOutput("t1 credits vc0", 64'(credCnt0 - c0), 64'd1);

    // Test 2: round-robin interleave starting from VC0.
    $display("[TB] test 2: round-robin");
    resetDut();
    ORDY = 2'b00; OACK = 2'b11; OLCK = 2'b00;
    c0 = credCnt0; c1 = credCnt1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, mkFlit((i == 0) ? FT_HEAD : (i == 1) ? FT_BODY : FT_TAIL, 1'b0, i));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, mkFlit((i == 0) ? FT_HEAD : (i == 1) ? FT_BODY : FT_TAIL, 1'b1, i));
    for (int i = 0; i < 3; i++) begin
      expQ.push_back('{1'b0, mkFlit((i == 0) ? FT_HEAD : (i == 1) ? FT_BODY : FT_TAIL, 1'b0, i)});
      expQ.push_back('{1'b1, mkFlit((i == 0) ? FT_HEAD : (i == 1) ? FT_BODY : FT_TAIL, 1'b1, i)});
    end
    ORDY = 2'b11;
    waitDrain("t2");
    checkOutput("t2 credits vc0", 64'(credCnt0 - c0), 64'd3);
    checkOutput("t2 credits vc1", 64'(credCnt1 - c1), 64'd3);

    // Test 3: VC0 locked, so its whole packet goes before VC1.
    $display("[TB] test 3: wormhole lock");
    ORDY = 2'b00;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, mkFlit((i == 0) ? FT_HEAD : (i == 1) ? FT_BODY : FT_TAIL, 1'b0, 8 + i));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, mkFlit((i == 0) ? FT_HEAD : (i == 1) ? FT_BODY : FT_TAIL, 1'b1, 8 + i));
    for (int i = 0; i < 3; i++) expQ.push_back('{1'b0, mkFlit((i == 0) ? FT_HEAD : (i == 1) ? FT_BODY : FT_TAIL, 1'b0, 8 + i)});
    for (int i = 0; i < 3; i++) expQ.push_back('{1'b1, mkFlit((i == 0) ? FT_HEAD : (i == 1) ? FT_BODY : FT_TAIL, 1'b1, 8 + i)});
    d0 = delivered;
    OLCK = 2'b01; ORDY = 2'b11;
    for (int n = 0; n < 50 && delivered < d0 + 3; n++) tick();
    checkOutput("t3 vc0 packet delivered", 64'(delivered - d0), 64'd3);
    tick();
    checkOutput("t3 locked idle", 64'(IVALID), 64'd0);
    tick();
    checkOutput("t3 locked idle 2", 64'(IVALID), 64'd0);
    OLCK = 2'b00;
    waitDrain("t3");

    // Test 4: stall holds the output register; OACK for the other VC is ignored.
    $display("[TB] test 4: output stall");
    ORDY = 2'b11; OACK = 2'b00;
    fA = 35'h123456789;
    fB = mkFlit(FT_SINGLE, 1'b1, 5);
    expQ.push_back('{1'b0, fA});
    applyStimulus(1'b0, fA);
    tick();
    checkOutput("t4 load credit", 64'(LCRED), 64'b01);
    expQ.push_back('{1'b1, fB});
    applyStimulus(1'b1, fB);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4 stall IVALID", 64'(IVALID), 64'd1);
      checkOutput("t4 stall IDATA", 64'(IDATA), 64'(fA));
      checkOutput("t4 stall IVCH", 64'(IVCH), 64'd0);
      checkOutput("t4 stall LCRED", 64'(LCRED), 64'b00);
      tick();
    end
    OACK = 2'b01;
    tick();
    checkOutput("t4 next IVCH", 64'(IVCH), 64'd1);
    checkOutput("t4 next IDATA", 64'(IDATA), 64'(fB));
    checkOutput("t4 next LCRED", 64'(LCRED), 64'b10);
    tick();
    checkOutput("t4 other-ack IVALID", 64'(IVALID), 64'd1);
    checkOutput("t4 other-ack IVCH", 64'(IVCH), 64'd1);
    checkOutput("t4 other-ack LCRED", 64'(LCRED), 64'b00);
    OACK = 2'b11;
    waitDrain("t4");

    // Test 5: overflow on VC1, then a push into a full FIFO that pops the same edge.
    $display("[TB] test 5: overflow");
    ORDY = 2'b01; OACK = 2'b11;
    c1 = credCnt1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expQ.push_back('{1'b1, mkFlit(FT_BODY, 1'b1, i)});
      applyStimulus(1'b1, mkFlit(FT_BODY, 1'b1, i));
      if (i == 3) begin
        checkOutput("t5 FULL at 4", 64'(FULL), 64'b10);
        checkOutput("t5 OVF at 4", 64'(OVF_ERR), 64'd0);
      end
    end
    checkOutput("t5 FULL after drop", 64'(FULL), 64'b10);
    checkOutput("t5 OVF after drop", 64'(OVF_ERR), 64'd1);
    ORDY = 2'b11;
    expQ.push_back('{1'b1, mkFlit(FT_TAIL, 1'b1, 6)});
    applyStimulus(1'b1, mkFlit(FT_TAIL, 1'b1, 6));
    checkOutput("t5 FULL push+pop", 64'(FULL), 64'b10);
    checkOutput("t5 LCRED push+pop", 64'(LCRED), 64'b10);
    waitDrain("t5");
    checkOutput("t5 OVF sticky", 64'(OVF_ERR), 64'd1);
    checkOutput("t5 FULL drained", 64'(FULL), 64'b00);
    checkOutput("t5 credits vc1", 64'(credCnt1 - c1), 64'd5);

    // Test 6: asynchronous reset mid-packet discards everything.
    $display("[TB] test 6: async reset");
    OACK = 2'b00; ORDY = 2'b11;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, mkFlit(FT_BODY, 1'b0, 12 + i));
    checkOutput("t6 IVALID before rst", 64'(IVALID), 64'd1);
    #2;
    RST_ = 1'b1;
    #1;
    checkOutput("t6 rst IVALID", 64'(IVALID), 64'd0);
    checkOutput("t6 rst IDATA", 64'(IDATA), 64'd0);
    checkOutput("t6 rst IVCH", 64'(IVCH), 64'd0);
    checkOutput("t6 rst LCRED", 64'(LCRED), 64'd0);
    checkOutput("t6 rst FULL", 64'(FULL), 64'd0);
    checkOutput("t6 rst OVF", 64'(OVF_ERR), 64'd0);
    tick();
    RST_ = 1'b0;
    c0 = credCnt0; c1 = credCnt1;
    OACK = 2'b11;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (IVALID) seen++;
    end
    checkOutput("t6 stale IVALID cycles", 64'(seen), 64'd0);
    checkOutput("t6 stale credits", 64'((credCnt0 - c0) + (credCnt1 - c1)), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
